// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Exports bus widths, reset PC, queue entry type and PC increment helper.
package fetch_unit_pkg;

    localparam int InstructionAddressBus = 32;
    localparam int InstructionBus        = 32;

    localparam logic [InstructionAddressBus-1:0] RstPc  = '0;
    localparam logic [InstructionAddressBus-1:0] PcStep =
        InstructionAddressBus'(4);

    typedef struct packed {
        logic [InstructionAddressBus-1:0] pc;
        logic [InstructionBus-1:0]        instr;
    } fetch_entry_t;

    // Sequential fetch advance; wraps modulo 2^InstructionAddressBus.
    function automatic logic [InstructionAddressBus-1:0] pc_inc(
        input logic [InstructionAddressBus-1:0] pc
    );
        return pc + PcStep;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instruction} entries toward decode.
// Ports: clk, rst_n, flush_i, push_i, pop_i, data_i -> data_o, full_o, empty_o.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam ptr_t LastPtr  = ptr_t'(Depth - 1);
    localparam cnt_t DepthCnt = cnt_t'(Depth);

    fetch_entry_t mem_q [Depth];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q,  count_d;

    logic do_push;
    logic do_pop;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);

    // A full queue refuses pushes even when a pop frees a slot this edge.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM request and redirect handling.
// Ports: clk, rst_n, rom_ce/rom_pc/rom_instruction, redirect_*, id_*.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int QueueDepth = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             rom_ce,
    output logic [InstructionAddressBus-1:0] rom_pc,
    input  logic [InstructionBus-1:0]        rom_instruction,
    input  logic                             redirect_valid,
    input  logic [InstructionAddressBus-1:0] redirect_pc,
    input  logic                             id_ready,
    output logic                             id_valid,
    output logic [InstructionAddressBus-1:0] id_pc,
    output logic [InstructionBus-1:0]        id_instruction
);

    logic [InstructionAddressBus-1:0] pc_q, pc_d;

    fetch_entry_t q_din;
    fetch_entry_t q_dout;
    logic         q_full;
    logic         q_empty;
    logic         q_pop;

    // Redirect wins over everything: no fetch, no pop, queue flushed.
    assign rom_ce = rst_n && !redirect_valid && !q_full;
    assign rom_pc = pc_q;

    assign q_din.pc    = pc_q;
    assign q_din.instr = rom_instruction;

    assign id_valid       = !q_empty;
    assign id_pc          = q_dout.pc;
    assign id_instruction = q_dout.instr;

    assign q_pop = id_valid && id_ready && !redirect_valid;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[InstructionAddressBus-1:2], 2'b00};
        end else if (rom_ce) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RstPc;
        else        pc_q <= pc_d;
    end

    fetch_queue #(
        .Depth (QueueDepth)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rom_ce),
        .pop_i   (q_pop),
        .data_i  (q_din),
        .data_o  (q_dout),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus corner sequences.
// Drives after the falling edge, samples 1ns later.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_pc;
    logic [31:0] rom_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    assign rom_instruction = rom_fn(rom_pc);

    fetch_unit #(
        .QueueDepth (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_ce          (rom_ce),
        .rom_pc          (rom_pc),
        .rom_instruction (rom_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction)
    );

    typedef struct packed {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ce;
        logic [31:0] rompc;
        logic        v;
        logic [31:0] idpc;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ce,
                           input logic [31:0] rpc, input logic v,
                           input logic [31:0] ipc);
        logic [31:0] ins;
        ins = v ? rom_fn(ipc) : 32'h0;
        chk({tag, " rom_ce"}, {31'b0, rom_ce}, {31'b0, ce});
        chk({tag, " rom_pc"}, rom_pc, rpc);
        chk({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, v});
        chk({tag, " id_pc"}, id_pc, v ? ipc : 32'h0);
        chk({tag, " id_instr"}, id_instruction, ins);
    endtask

    task automatic drive(input logic r, input logic rv,
                         input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst_n          = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        id_ready       = rdy;
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        drive(1'b0, 1'b0, 32'h0, rdy);
        drive(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 1'b1, 32'hC};
        vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h18, 1'b1, 32'hC};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'hC};
        vecs[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'hC};
        vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'hC};
        vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 32'h203, 1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
        vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 1'b1, 32'h200};
        vecs[15] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1,
                     1'b0, 32'h208, 1'b1, 32'h204};
        vecs[16] = '{1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC};
        vecs[18] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            chk_out($sformatf("v%0d", i), vecs[i].ce, vecs[i].rompc,
                    vecs[i].v, vecs[i].idpc);
        end

        // Backpressure from reset: four pushes, stall, resume after pop.
        do_reset(1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp0", 1'b1, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp1", 1'b1, 32'h4, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp2", 1'b1, 32'h8, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp3", 1'b1, 32'hC, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp_full", 1'b0, 32'h10, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("bp_hold", 1'b0, 32'h10, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("bp_pop0", 1'b0, 32'h10, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("bp_resume", 1'b1, 32'h10, 1'b1, 32'h4);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("bp_next", 1'b1, 32'h14, 1'b1, 32'h8);

        // Redirect with three entries queued and decode ready.
        do_reset(1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h100, 1'b1);
        chk_out("rd_cyc", 1'b0, 32'hC, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("rd_n1", 1'b1, 32'h100, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("rd_n2", 1'b1, 32'h104, 1'b1, 32'h100);

        // Asynchronous reset mid-stream with a full queue.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk_out("ar_full", 1'b0, 32'h10, 1'b1, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar_async", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("ar_rel", 1'b1, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_out("ar_first", 1'b1, 32'h4, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide the parameter QueueDepth, default 4, giving the number of fetched-instruction entries buffered toward decode.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL provide port rom_ce, output, 1 bit: instruction ROM read enable.
REQ-005 The block SHALL provide port rom_pc, output, 32 bits: ROM byte address.
REQ-006 The block SHALL provide port rom_instruction, input, 32 bits: combinational ROM read data for rom_pc.
REQ-007 The block SHALL provide port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 The block SHALL provide port redirect_pc, input, 32 bits: redirect target.
REQ-009 The block SHALL provide port id_ready, input, 1 bit: decode accepts the head entry.
REQ-010 The block SHALL provide port id_valid, output, 1 bit: head entry present.
REQ-011 The block SHALL provide port id_pc, output, 32 bits: PC of the head entry.
REQ-012 The block SHALL provide port id_instruction, output, 32 bits: instruction of the head entry.

Function
REQ-013 The block SHALL hold a 32-bit fetch PC register and a circular queue of QueueDepth {pc, instruction} entries with read/write pointers and a count of 0..QueueDepth.
REQ-014 The block SHALL drive rom_ce = rst_n && !redirect_valid && (count < QueueDepth) combinationally, and rom_pc = fetch PC at all times.
REQ-015 The block SHALL, on a clock edge where rom_ce=1, push {rom_pc, rom_instruction} at the write pointer and set fetch PC to fetch PC + 4.
REQ-016 The block SHALL compute fetch PC + 4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-017 The block SHALL drive id_valid = (count != 0), with id_pc/id_instruction taken from the head entry; when id_valid=0 they SHALL be 0.
REQ-018 The block SHALL pop the head on an edge where id_valid && id_ready && !redirect_valid.
REQ-019 The block SHALL block pushes whenever count == QueueDepth, even if a pop occurs in the same cycle; when 0 < count < QueueDepth, simultaneous push and pop SHALL leave count unchanged.
REQ-020 The block SHALL wrap both pointers modulo QueueDepth.
REQ-021 The block SHALL give redirect_valid absolute priority: on that edge the queue empties (count=0, pointers=0), no push or pop occurs, and fetch PC = {redirect_pc[31:2], 2'b00}.
REQ-022 The block SHALL provide redirect latency as follows: redirect asserted in cycle N → rom_pc = target in N+1 → id_valid=1 with id_pc = target in N+2.
REQ-023 The block SHALL provide steady-state throughput with id_ready held high of one instruction per cycle, with first-entry latency of one cycle from fetch to id_valid.
REQ-024 The block SHALL require decode to ignore id_valid during a redirect cycle, since the head shown in that cycle is discarded.

Reset
REQ-025 The block SHALL, while rst_n=0, asynchronously force fetch PC=0x00000000, count=0, and pointers=0.
REQ-026 The block SHALL, while rst_n=0, drive id_valid=0, id_pc=0, id_instruction=0, and rom_ce=0.
REQ-027 The block SHALL issue rom_ce=1 with rom_pc=0x00000000 in the first cycle after rst_n rises.
REQ-028 The block SHALL, on reset assertion mid-operation, discard all queued entries and any pending redirect.

Structure
REQ-029 The block SHALL take the bus widths (InstructionAddressBus, InstructionBus) and the reset PC value from the shared define.v; it SHALL add no local width literals.
REQ-030 The block SHALL implement the queue as one sub-module, fetch_queue (push/pop/flush, full/empty, data in/out); PC and control logic SHALL remain in fetch_unit.

Verification
REQ-031 Reset release, id_ready=1, ROM word = address → id_pc sequence SHALL be 0x0, 0x4, 0x8… at one per cycle, with id_valid first high one cycle after release.
REQ-032 id_ready=0 from reset → exactly 4 pushes (PCs 0x0–0xC), then rom_ce=0 and count=4; raising id_ready SHALL pop 0x0 first and resume fetch at 0x10 only after count < 4.
REQ-033 Redirect to 0x100 with 3 entries queued and id_ready=1 → no pop that edge; next cycle rom_pc=0x100, id_valid=0; cycle after that, id_pc=0x100.
REQ-034 Redirect to 0x203 → fetch PC SHALL become 0x200.
REQ-035 Redirect to 0xFFFFFFFC with id_ready=1 → id_pc SHALL be 0xFFFFFFFC, then 0x00000000.
REQ-036 rst_n pulled low mid-stream with a full queue → id_valid=0 and rom_ce=0 immediately, without waiting for a clock edge; after release, fetch SHALL restart at 0x0.
